// File: rtl/clk_div_cfg_ctrl.sv
// Programmable clock divider with a handshake-loaded divide factor.
// New factors take effect only at the end of a low phase so clk_out never glitches.
module clk_div_cfg_ctrl #(
  parameter int unsigned MAX_DIV = 20,
  parameter bit          RST_EN  = 1'b1,
  localparam int unsigned W      = $clog2(MAX_DIV) + 1
) (
  input  logic         clk_in,
  input  logic         rst_n,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [W-1:0] cfg_div,
  input  logic         cfg_en,
  output logic         cfg_err,
  output logic         clk_out,
  output logic [W-1:0] cur_div,
  output logic         busy,
  output logic         rise_tick
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PEND = 2'd2
  } state_t;

  state_t       r_state;
  logic [W-1:0] r_cnt;
  logic [W-1:0] r_cur_div;
  logic [W-1:0] r_pend_div;
  logic         r_pend_en;
  logic         r_clk_out;
  logic         r_cfg_ready;
  logic         r_busy;
  logic         r_cfg_err;
  logic         r_rise_tick;

  logic [W-1:0] w_half_m1;
  logic         w_tc;
  logic         w_legal;
  logic         w_xfer;
  logic         w_accept;

  // Terminal count of the half-period counter and request qualification
  assign w_half_m1 = (r_cur_div >> 1) - W'(1);
  assign w_tc      = (r_cnt == w_half_m1);
  assign w_legal   = ~cfg_div[0] && (cfg_div >= W'(2)) && (cfg_div <= W'(MAX_DIV));
  assign w_xfer    = cfg_valid && r_cfg_ready;
  assign w_accept  = w_xfer && w_legal;

  // Control FSM, half-period counter and all registered outputs
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RST_EN ? S_RUN : S_IDLE;
      r_cnt       <= '0;
      r_cur_div   <= W'(MAX_DIV);
      r_pend_div  <= '0;
      r_pend_en   <= 1'b0;
      r_clk_out   <= 1'b0;
      r_cfg_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_rise_tick <= 1'b0;
    end else begin
      r_cfg_err   <= w_xfer && !w_legal;
      r_rise_tick <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cur_div <= cfg_div;
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
            r_state   <= cfg_en ? S_RUN : S_IDLE;
          end
        end
        S_RUN: begin
          if (w_tc) begin
            r_cnt       <= '0;
            r_clk_out   <= ~r_clk_out;
            r_rise_tick <= ~r_clk_out;
          end else begin
            r_cnt <= r_cnt + W'(1);
          end
          if (w_accept) begin
            r_pend_div  <= cfg_div;
            r_pend_en   <= cfg_en;
            r_state     <= S_PEND;
            r_cfg_ready <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        S_PEND: begin
          if (w_tc && !r_clk_out) begin
            // End of low phase: swap in the held factor
            r_cnt       <= '0;
            r_cur_div   <= r_pend_div;
            r_busy      <= 1'b0;
            r_cfg_ready <= 1'b1;
            r_pend_div  <= '0;
            r_pend_en   <= 1'b0;
            if (r_pend_en) begin
              r_clk_out   <= 1'b1;
              r_rise_tick <= 1'b1;
              r_state     <= S_RUN;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (w_tc) begin
            r_cnt     <= '0;
            r_clk_out <= ~r_clk_out;
          end else begin
            r_cnt <= r_cnt + W'(1);
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_cnt       <= '0;
          r_clk_out   <= 1'b0;
          r_cfg_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_ready = r_cfg_ready;
  assign cfg_err   = r_cfg_err;
  assign clk_out   = r_clk_out;
  assign cur_div   = r_cur_div;
  assign busy      = r_busy;
  assign rise_tick = r_rise_tick;

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// Self-checking bench for clk_div_cfg_ctrl (MAX_DIV = 20, RST_EN = 1).
// A period-position model is compared every cycle; directed checks pin phase lengths.
module tb_clk_div_cfg_ctrl;

  localparam int unsigned MAX_DIV = 20;
  localparam int unsigned W       = $clog2(MAX_DIV) + 1;

  logic         clk_in    = 1'b0;
  logic         rst_n     = 1'b0;
  logic         cfg_valid = 1'b0;
  logic [W-1:0] cfg_div   = '0;
  logic         cfg_en    = 1'b0;
  logic         cfg_ready;
  logic         cfg_err;
  logic         clk_out;
  logic [W-1:0] cur_div;
  logic         busy;
  logic         rise_tick;

  clk_div_cfg_ctrl #(.MAX_DIV(MAX_DIV), .RST_EN(1'b1)) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
    .cfg_en    (cfg_en),
    .cfg_err   (cfg_err),
    .clk_out   (clk_out),
    .cur_div   (cur_div),
    .busy      (busy),
    .rise_tick (rise_tick)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position within a full output period; low half first, then high half
  bit m_active;
  bit m_pend;
  bit m_pen;
  bit m_err;
  bit m_rise;
  int m_div;
  int m_pos;
  int m_pdiv;

  function automatic bit m_clk();
    return m_active && (m_pos >= m_div / 2);
  endfunction

  task automatic model_reset();
    m_active = 1'b1;
    m_pend   = 1'b0;
    m_pen    = 1'b0;
    m_err    = 1'b0;
    m_rise   = 1'b0;
    m_div    = MAX_DIV;
    m_pos    = 0;
    m_pdiv   = 0;
  endtask

  initial model_reset();

  // Advance the model on each rising edge, then compare shortly after
  always @(posedge clk_in) begin
    bit old_clk;
    bit was_pend;
    bit xfer;
    bit legal;
    int req;
    if (!rst_n) begin
      model_reset();
    end else begin
      old_clk  = m_clk();
      was_pend = m_pend;
      req      = int'(cfg_div);
      xfer     = cfg_valid && !was_pend;
      legal    = (req % 2 == 0) && (req >= 2) && (req <= MAX_DIV);
      m_err    = xfer && !legal;
      if (!m_active) begin
        if (xfer && legal) begin
          m_div    = req;
          m_pos    = 0;
          m_active = cfg_en;
        end
      end else begin
        if (was_pend && (m_pos == m_div / 2 - 1)) begin
          m_pend = 1'b0;
          m_div  = m_pdiv;
          if (m_pen) m_pos = m_div / 2;
          else begin
            m_active = 1'b0;
            m_pos    = 0;
          end
        end else begin
          m_pos = (m_pos + 1) % m_div;
        end
        if (xfer && legal) begin
          m_pend = 1'b1;
          m_pdiv = req;
          m_pen  = cfg_en;
        end
      end
      m_rise = m_clk() && !old_clk;
    end
    #1;
    check("cyc_clk_out",   int'(clk_out),   int'(m_clk()));
    check("cyc_cur_div",   int'(cur_div),   m_div);
    check("cyc_busy",      int'(busy),      int'(m_pend));
    check("cyc_cfg_ready", int'(cfg_ready), int'(!m_pend));
    check("cyc_cfg_err",   int'(cfg_err),   int'(m_err));
    check("cyc_rise_tick", int'(rise_tick), int'(m_rise));
  end

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_in);
  endtask

  // One-cycle config request; returns at the negedge after the transfer edge
  task automatic drive_cfg(input int div, input bit en);
    @(negedge clk_in);
    cfg_valid = 1'b1;
    cfg_div   = W'(div);
    cfg_en    = en;
    @(negedge clk_in);
    cfg_valid = 1'b0;
  endtask

  // Count consecutive negedge samples at level lvl (waits for lvl first)
  task automatic run_len(input logic lvl, output int n);
    int k;
    k = 0;
    while (clk_out != lvl && k < 100) begin
      @(negedge clk_in);
      k++;
    end
    if (k >= 100) check("wait_level_timeout", k, 0);
    n = 0;
    while (clk_out == lvl && n < 100) begin
      n++;
      @(negedge clk_in);
    end
  endtask

  task automatic wait_rise(output int k);
    k = 0;
    while (!clk_out && k < 100) begin
      @(negedge clk_in);
      k++;
    end
  endtask

  initial begin
    int n;
    int k;
    int bad [3];
    bad[0] = 7;
    bad[1] = 22;
    bad[2] = 0;

    // Reset values
    wait_neg(3);
    check("rst_clk_out",   int'(clk_out),   0);
    check("rst_cur_div",   int'(cur_div),   20);
    check("rst_busy",      int'(busy),      0);
    check("rst_cfg_ready", int'(cfg_ready), 1);
    check("rst_cfg_err",   int'(cfg_err),   0);
    check("rst_rise_tick", int'(rise_tick), 0);

    // Free-running divide by 20 after release
    rst_n = 1'b1;
    wait_rise(k);
    check("first_rise_delay", k, 10);
    check("first_rise_tick", int'(rise_tick), 1);
    run_len(1'b1, n); check("div20_high", n, 10);
    run_len(1'b0, n); check("div20_low", n, 10);
    run_len(1'b1, n); check("div20_high2", n, 10);

    // Reconfigure to 6 in the middle of a low phase
    wait_neg(3);
    drive_cfg(6, 1'b1);
    check("pend6_busy", int'(busy), 1);
    check("pend6_ready", int'(cfg_ready), 0);
    wait_rise(k);
    check("div6_cur_div", int'(cur_div), 6);
    run_len(1'b1, n); check("div6_high", n, 3);
    run_len(1'b0, n); check("div6_low", n, 3);
    run_len(1'b1, n); check("div6_high2", n, 3);

    // Illegal factors are rejected with a single error pulse
    for (int i = 0; i < 3; i++) begin
      drive_cfg(bad[i], 1'b1);
      check("bad_err_pulse", int'(cfg_err), 1);
      check("bad_ready", int'(cfg_ready), 1);
      check("bad_cur_div", int'(cur_div), 6);
      @(negedge clk_in);
      check("bad_err_clear", int'(cfg_err), 0);
    end
    run_len(1'b1, n); check("div6_after_bad_high", n, 3);
    run_len(1'b0, n); check("div6_after_bad_low", n, 3);

    // Stop via config with en = 0, then restart at divide by 2
    drive_cfg(4, 1'b0);
    k = 0;
    while (busy && k < 50) begin
      @(negedge clk_in);
      k++;
    end
    check("stop_busy_drop", int'(busy), 0);
    check("stop_clk_low", int'(clk_out), 0);
    check("stop_cur_div", int'(cur_div), 4);
    wait_neg(5);
    check("idle_clk_low", int'(clk_out), 0);
    drive_cfg(2, 1'b1);
    check("div2_first_low", int'(clk_out), 0);
    @(negedge clk_in); check("div2_t1", int'(clk_out), 1);
    @(negedge clk_in); check("div2_t2", int'(clk_out), 0);
    @(negedge clk_in); check("div2_t3", int'(clk_out), 1);

    // Back to 20, then hold a pending config and reset in the middle of it
    drive_cfg(20, 1'b1);
    k = 0;
    while (busy && k < 50) begin
      @(negedge clk_in);
      k++;
    end
    check("back20_cur_div", int'(cur_div), 20);
    drive_cfg(8, 1'b1);
    check("pend8_busy", int'(busy), 1);
    check("pend8_ready", int'(cfg_ready), 0);
    drive_cfg(7, 1'b1);
    check("pend_ignore_err", int'(cfg_err), 0);
    check("pend_ignore_busy", int'(busy), 1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_cur_div", int'(cur_div), 20);
    check("midrst_clk_out", int'(clk_out), 0);
    check("midrst_ready", int'(cfg_ready), 1);
    wait_neg(2);
    rst_n = 1'b1;
    wait_rise(k);
    check("rerst_rise_delay", k, 10);
    check("rerst_cur_div", int'(cur_div), 20);
    wait_neg(4);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

endmodule
